pipe_data_serializer: RTL and testbench

PIPE_DATA_SERIALIZER -- requirements
Module: pipe_data_serializer

---
 rtl/debug_pkg.sv | 16 +
 rtl/pipe_data_serializer_if.sv | 24 ++
 rtl/pipe_data_serializer_byte_select.sv | 18 +
 rtl/pipe_data_serializer.sv | 107 ++++++++++
 tb/tb_pipe_data_serializer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug package: serializer FSM states and byte width
package debug_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } ser_state_t;

  function automatic int bytes_for_width(input int width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/pipe_data_serializer_if.sv
// rtl/pipe_data_serializer_if.sv - snapshot capture and UART Tx byte handshake bundle
import debug_pkg::*;

interface pipe_data_serializer_if #(
  parameter int DATA_W = 2558
);
  logic [DATA_W-1:0] i_data;
  logic              is_start;
  logic              is_tx_done;
  logic [BYTE_W-1:0] o_tx_data;
  logic              os_tx_start;
  logic              os_busy;
  logic              os_done;

  modport master (
    output i_data, is_start, is_tx_done,
    input  o_tx_data, os_tx_start, os_busy, os_done
  );

  modport slave (
    input  i_data, is_start, is_tx_done,
    output o_tx_data, os_tx_start, os_busy, os_done
  );
endinterface

// File: rtl/pipe_data_serializer_byte_select.sv
// rtl/pipe_data_serializer_byte_select.sv - byte_select: picks shadow byte idx, 0 when idx is past the payload
import debug_pkg::*;

module byte_select #(
  parameter int NBYTES = 1,
  parameter int IDX_W  = 1
) (
  input  logic [NBYTES*BYTE_W-1:0] i_shadow,
  input  logic [IDX_W-1:0]         i_idx,
  output logic [BYTE_W-1:0]        o_byte
);
  always_comb begin
    o_byte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (i_idx == IDX_W'(b)) o_byte = i_shadow[b*BYTE_W +: BYTE_W];
    end
  end
endmodule

// File: rtl/pipe_data_serializer.sv
// rtl/pipe_data_serializer.sv - captures a pipeline snapshot and streams it LSB byte first to a UART Tx
// Optional SER_CHECKSUM_EN appends an XOR-of-payload byte to every frame.
import debug_pkg::*;

module pipe_data_serializer #(
  parameter int DATA_W = 2558
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_data_serializer_if.slave bus
);
  localparam int NBYTES = bytes_for_width(DATA_W);
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int PAD_W  = NBYTES * BYTE_W;
`ifdef SER_CHECKSUM_EN
  localparam int NSEND  = NBYTES + 1;
`else
  localparam int NSEND  = NBYTES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEND - 1);

  ser_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [PAD_W-1:0]  r_shadow, w_shadow_nxt;
  logic              r_done, w_done_nxt;
  logic [BYTE_W-1:0] w_byte;

  byte_select #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_byte_select (
    .i_shadow (r_shadow),
    .i_idx    (r_idx),
    .o_byte   (w_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // A start seen while os_done is still high belongs to the finished frame and is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.is_start && !r_done) begin
          w_shadow_nxt = PAD_W'(bus.i_data);
          w_idx_nxt    = '0;
          w_state_nxt  = SEND;
        end
      end
      SEND: w_state_nxt = WAIT;
      WAIT: begin
        if (bus.is_tx_done) begin
          if (r_idx == LAST_IDX) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = SEND;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum, w_csum_nxt;

  // Running XOR folds in each payload byte as its transmission completes.
  always_comb begin
    w_csum_nxt = r_csum;
    if (r_state == IDLE && bus.is_start && !r_done) begin
      w_csum_nxt = '0;
    end else if (r_state == WAIT && bus.is_tx_done && r_idx != LAST_IDX) begin
      w_csum_nxt = r_csum ^ w_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_csum <= '0;
    else     r_csum <= w_csum_nxt;
  end

  assign bus.o_tx_data = (r_idx == IDX_W'(NBYTES)) ? r_csum : w_byte;
`else
  assign bus.o_tx_data = w_byte;
`endif

  assign bus.os_tx_start = (r_state == SEND);
  assign bus.os_busy     = (r_state != IDLE);
  assign bus.os_done     = r_done;
endmodule

// File: tb/tb_pipe_data_serializer.sv
// tb/tb_pipe_data_serializer.sv - self-checking bench: 20-bit and default-width serializers with Tx models
module tb_pipe_data_serializer;

  localparam int BIG_W  = 2558;
  localparam int BIG_NB = 320;

  logic clk;
  logic rst;

  pipe_data_serializer_if #(.DATA_W(20))    sif();
  pipe_data_serializer_if #(.DATA_W(BIG_W)) bif();

  pipe_data_serializer #(.DATA_W(20)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  pipe_data_serializer u_big (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic s_model_done, s_spur, b_model_done;
  assign sif.is_tx_done = s_model_done | s_spur;
  assign bif.is_tx_done = b_model_done;

  // Tx models: is_tx_done pulses 10 cycles after each os_tx_start
  initial begin
    int cnt;
    cnt = 0;
    s_model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.os_tx_start) cnt = 10;
      @(posedge clk); #1;
      s_model_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) s_model_done = 1'b1;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    b_model_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.os_tx_start) cnt = 10;
      @(posedge clk); #1;
      b_model_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) b_model_done = 1'b1;
      end
    end
  end

  // Scoreboards
  logic [7:0] sq[$];
  logic [7:0] bq[$];
  int s_n_start = 0, s_n_done = 0, b_n_start = 0, b_n_done = 0;
  logic s_prev_txd = 1'b0;

  always @(negedge clk) begin
    if (sif.os_tx_start) begin
      s_n_start++;
      if (sq.size() == 0) chk("small_unexpected_tx_start", 1, 0);
      else chk("small_byte", sif.o_tx_data, sq.pop_front());
    end
    if (sif.os_done) begin
      s_n_done++;
      chk("small_done_after_tx_done", s_prev_txd, 1);
      chk("small_done_bytes_left", sq.size(), 0);
    end
    s_prev_txd = sif.is_tx_done;
  end

  always @(negedge clk) begin
    if (bif.os_tx_start) begin
      if (bq.size() == 0) chk("big_unexpected_tx_start", 1, 0);
      else chk("big_byte", bif.o_tx_data, bq.pop_front());
      if (b_n_start == BIG_NB - 1) chk("big_last_byte_pad", bif.o_tx_data[7:6], 2'b00);
      b_n_start++;
    end
    if (bif.os_done) b_n_done++;
  end

  typedef struct {
    logic [19:0] data;
    logic [7:0]  b0, b1, b2, csum;
  } vec_t;

  vec_t vecs[5];

  task automatic pulse_small_start(input logic [19:0] d);
    @(posedge clk); #1;
    sif.i_data   = d;
    sif.is_start = 1'b1;
    @(posedge clk); #1;
    sif.is_start = 1'b0;
  endtask

  task automatic push_small(input vec_t v);
    sq.push_back(v.b0);
    sq.push_back(v.b1);
    sq.push_back(v.b2);
`ifdef SER_CHECKSUM_EN
    sq.push_back(v.csum);
`endif
  endtask

  task automatic wait_small_done(input int budget, input string name);
    int base, k;
    base = s_n_done;
    k = 0;
    while (s_n_done == base && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({name, "_done_count"}, s_n_done - base, 1);
    chk({name, "_queue_drained"}, sq.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2559:0] raw;
    logic [BIG_W-1:0] bdata;
    logic [8*BIG_NB-1:0] bpad;
    logic [7:0] bcsum;
    int base, k;

    vecs[0] = '{20'hABCDE, 8'hDE, 8'hBC, 8'h0A, 8'h68};
    vecs[1] = '{20'h12345, 8'h45, 8'h23, 8'h01, 8'h67};
    vecs[2] = '{20'hFFFFF, 8'hFF, 8'hFF, 8'h0F, 8'h0F};
    vecs[3] = '{20'h00000, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{20'h80001, 8'h01, 8'h00, 8'h08, 8'h09};

    rst = 1'b1;
    s_spur = 1'b0;
    sif.i_data = '0;
    sif.is_start = 1'b0;
    bif.i_data = '0;
    bif.is_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tx_data", sif.o_tx_data, 0);
    chk("reset_tx_start", sif.os_tx_start, 0);
    chk("reset_busy", sif.os_busy, 0);
    chk("reset_done", sif.os_done, 0);
    chk("reset_big_busy", bif.os_busy, 0);
    chk("reset_big_tx_data", bif.o_tx_data, 0);

    for (int i = 0; i < 5; i++) begin
      push_small(vecs[i]);
      pulse_small_start(vecs[i].data);
      @(negedge clk);
      chk("table_busy", sif.os_busy, 1);
      wait_small_done(200, "table");
      idle_cycles(2);
    end

    // Start re-pulsed during WAIT with new data
    push_small(vecs[0]);
    pulse_small_start(vecs[0].data);
    idle_cycles(5);
    pulse_small_start(20'h12345);
    wait_small_done(200, "restart_ignored");
    base = s_n_start;
    idle_cycles(30);
    chk("restart_no_second_frame", s_n_start - base, 0);
    chk("restart_idle_busy", sif.os_busy, 0);

    // Start coincident with os_done
    push_small(vecs[1]);
    pulse_small_start(vecs[1].data);
    k = 0;
    while (!sif.os_done && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("coinc_done_seen", sif.os_done, 1);
    sif.is_start = 1'b1;
    @(posedge clk); #1;
    sif.is_start = 1'b0;
    base = s_n_start;
    @(negedge clk);
    chk("coinc_start_busy", sif.os_busy, 0);
    idle_cycles(20);
    chk("coinc_start_no_frame", s_n_start - base, 0);

    // Spurious tx_done in IDLE, then coincident with os_tx_start
    base = s_n_start;
    @(posedge clk); #1 s_spur = 1'b1;
    @(posedge clk); #1 s_spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", sif.os_busy, 0);
    idle_cycles(15);
    chk("spur_idle_no_start", s_n_start - base, 0);
    push_small(vecs[2]);
    pulse_small_start(vecs[2].data);
    s_spur = 1'b1;
    @(negedge clk);
    chk("spur_coincident_tx_start", sif.os_tx_start, 1);
    @(posedge clk); #1 s_spur = 1'b0;
    wait_small_done(200, "spur_frame");
    idle_cycles(20);

    // Reset in WAIT of byte 1
    push_small(vecs[0]);
    base = s_n_start;
    pulse_small_start(vecs[0].data);
    k = 0;
    while (s_n_start - base < 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("abort_reached_byte1", s_n_start - base, 2);
    idle_cycles(2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_data", sif.o_tx_data, 0);
    chk("abort_tx_start", sif.os_tx_start, 0);
    chk("abort_busy", sif.os_busy, 0);
    chk("abort_done", sif.os_done, 0);
    sq.delete();
    base = s_n_done;
    idle_cycles(30);
    chk("abort_no_done", s_n_done - base, 0);
    push_small(vecs[0]);
    pulse_small_start(vecs[0].data);
    wait_small_done(200, "after_abort");

    // Full-width random snapshot
    for (int w = 0; w < 80; w++) raw[w*32 +: 32] = $urandom;
    bdata = raw[BIG_W-1:0];
    bdata[BIG_W-1] = 1'b1;
    bpad = {2'b00, bdata};
    bcsum = '0;
    for (int b = 0; b < BIG_NB; b++) begin
      bq.push_back(bpad[b*8 +: 8]);
      bcsum = bcsum ^ bpad[b*8 +: 8];
    end
`ifdef SER_CHECKSUM_EN
    bq.push_back(bcsum);
`endif
    base = b_n_done;
    b_n_start = 0;
    @(posedge clk); #1;
    bif.i_data = bdata;
    bif.is_start = 1'b1;
    @(posedge clk); #1;
    bif.is_start = 1'b0;
    k = 0;
    while (b_n_done == base && k < 6000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("big_done_count", b_n_done - base, 1);
    chk("big_queue_drained", bq.size(), 0);
`ifdef SER_CHECKSUM_EN
    chk("big_tx_start_count", b_n_start, BIG_NB + 1);
`else
    chk("big_tx_start_count", b_n_start, BIG_NB);
`endif
    idle_cycles(5);
    chk("big_idle_busy", bif.os_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
